// File: rtl/ex_mem_pkg.sv
// Shared types and constants for the EX->MEM pipeline stage register.
// The payload struct and width constants describe the default configuration.
package ex_mem_pkg;

  localparam int XLEN_D        = 32;
  localparam int RIDX_W_D      = 5;
  localparam int ILEN_D        = 32;
  localparam int ITYPE_W_D     = 4;
  localparam int STALL_CNT_W_D = 16;

  localparam logic [ITYPE_W_D-1:0] ITYPE_ALU    = 4'd0;
  localparam logic [ITYPE_W_D-1:0] ITYPE_LOAD   = 4'd1;
  localparam logic [ITYPE_W_D-1:0] ITYPE_STORE  = 4'd2;
  localparam logic [ITYPE_W_D-1:0] ITYPE_BRANCH = 4'd3;
  localparam logic [ITYPE_W_D-1:0] ITYPE_JUMP   = 4'd4;
  localparam logic [ITYPE_W_D-1:0] ITYPE_SYSTEM = 4'd5;

  // Field order here is the packing order of the flat payload vector in the stage.
  typedef struct packed {
    logic [XLEN_D-1:0]    alu_result;
    logic [XLEN_D-1:0]    rs2_val;
    logic [RIDX_W_D-1:0]  rd_idx;
    logic                 rd_we;
    logic [ILEN_D-1:0]    instr;
    logic [ITYPE_W_D-1:0] instr_type;
  } ex_mem_payload_t;

  function automatic int payload_width(input int xlen, input int ridx_w,
                                       input int ilen, input int itype_w);
    return 2 * xlen + ridx_w + 1 + ilen + itype_w;
  endfunction

endpackage

// File: rtl/pipe_skid_buf.sv
// Generic one-entry skid buffer in front of a main output register.
// Only built when EX_MEM_SKID_EN is defined; upstream ready is registered.
`ifdef EX_MEM_SKID_EN
module pipe_skid_buf #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         s_valid,
  output logic         s_ready,
  input  logic [W-1:0] s_data,
  output logic         m_valid,
  input  logic         m_ready,
  output logic [W-1:0] m_data
);

  logic         main_valid;
  logic         skid_valid;
  logic [W-1:0] main_data;
  logic [W-1:0] skid_data;
  logic         up;
  logic         hold;

  assign s_ready = !skid_valid;
  assign up      = s_valid && s_ready;
  assign hold    = main_valid && !m_ready;
  assign m_valid = main_valid;
  assign m_data  = main_data;

  // Park an accepted beat in the skid slot while main is stalled; refill main from skid first.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      main_data  <= '0;
      skid_data  <= '0;
    end else begin
      if (flush) begin
        main_valid <= 1'b0;
        skid_valid <= 1'b0;
      end else if (hold) begin
        if (up) skid_valid <= 1'b1;
      end else if (skid_valid) begin
        main_valid <= 1'b1;
        skid_valid <= 1'b0;
      end else begin
        main_valid <= up;
      end

      if (hold) begin
        if (up) skid_data <= s_data;
      end else if (skid_valid) begin
        main_data <= skid_data;
      end else if (up) begin
        main_data <= s_data;
      end
    end
  end

endmodule
`endif

// File: rtl/ex_mem_stage_rg.sv
// EX->MEM stage register with valid/ready handshake, flush and saturating stall counter.
// Optional macro EX_MEM_SKID_EN adds a skid buffer so in_ready is registered.
module ex_mem_stage_rg
  import ex_mem_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int RIDX_W      = 5,
  parameter int ILEN        = 32,
  parameter int ITYPE_W     = 4,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [XLEN-1:0]        alu_result,
  input  logic [XLEN-1:0]        rs2_val,
  input  logic [RIDX_W-1:0]      rd_idx,
  input  logic                   rd_we,
  input  logic [ILEN-1:0]        instr,
  input  logic [ITYPE_W-1:0]     instr_type,
  input  logic                   flush,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [XLEN-1:0]        alu_result_out,
  output logic [XLEN-1:0]        rs2_val_out,
  output logic [RIDX_W-1:0]      rd_idx_out,
  output logic                   rd_we_out,
  output logic [ILEN-1:0]        instr_out,
  output logic [ITYPE_W-1:0]     instr_type_out,
  output logic [STALL_CNT_W-1:0] stall_cnt
);

  localparam int PW = payload_width(XLEN, RIDX_W, ILEN, ITYPE_W);

  logic [PW-1:0] in_pl;
  logic [PW-1:0] out_pl;
  logic          valid_q;
  logic          stored_we;

  assign in_pl = {alu_result, rs2_val, rd_idx, rd_we, instr, instr_type};

`ifdef EX_MEM_SKID_EN
  pipe_skid_buf #(
    .W(PW)
  ) u_skid (
    .clk     (clk),
    .rst     (rst),
    .flush   (flush),
    .s_valid (in_valid),
    .s_ready (in_ready),
    .s_data  (in_pl),
    .m_valid (valid_q),
    .m_ready (out_ready),
    .m_data  (out_pl)
  );
`else
  logic up;

  assign in_ready = !valid_q || out_ready;
  assign up       = in_valid && in_ready;

  // Single output register; flush wins, a new beat replaces a departing one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      out_pl  <= '0;
    end else begin
      if (flush) valid_q <= 1'b0;
      else if (up) valid_q <= 1'b1;
      else if (valid_q && out_ready) valid_q <= 1'b0;
      if (up) out_pl <= in_pl;
    end
  end
`endif

  assign out_valid = valid_q;
  assign {alu_result_out, rs2_val_out, rd_idx_out, stored_we, instr_out, instr_type_out} = out_pl;
  assign rd_we_out = stored_we && valid_q;

  // Count stalled cycles, sticking at all-ones; only reset clears it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (valid_q && !out_ready && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_ex_mem_stage_rg.sv
// Self-checking bench for ex_mem_stage_rg with a scoreboard queue of expected beats.
// Expectations adapt when EX_MEM_SKID_EN is defined.
module tb_ex_mem_stage_rg;
  import ex_mem_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] alu_result;
  logic [31:0] rs2_val;
  logic [4:0]  rd_idx;
  logic        rd_we;
  logic [31:0] instr;
  logic [3:0]  instr_type;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] alu_result_out;
  logic [31:0] rs2_val_out;
  logic [4:0]  rd_idx_out;
  logic        rd_we_out;
  logic [31:0] instr_out;
  logic [3:0]  instr_type_out;
  logic [15:0] stall_cnt;

  logic        sat_in_ready;
  logic        sat_out_valid;
  logic [31:0] sat_alu_result_out;
  logic [31:0] sat_rs2_val_out;
  logic [4:0]  sat_rd_idx_out;
  logic        sat_rd_we_out;
  logic [31:0] sat_instr_out;
  logic [3:0]  sat_instr_type_out;
  logic [3:0]  sat_stall_cnt;

  int vectors = 0;
  int errors  = 0;
  ex_mem_payload_t sb[$];

`ifdef EX_MEM_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif

  ex_mem_stage_rg dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .alu_result(alu_result), .rs2_val(rs2_val), .rd_idx(rd_idx), .rd_we(rd_we),
    .instr(instr), .instr_type(instr_type), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .alu_result_out(alu_result_out), .rs2_val_out(rs2_val_out),
    .rd_idx_out(rd_idx_out), .rd_we_out(rd_we_out), .instr_out(instr_out),
    .instr_type_out(instr_type_out), .stall_cnt(stall_cnt)
  );

  ex_mem_stage_rg #(.STALL_CNT_W(4)) dut_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(sat_in_ready),
    .alu_result(alu_result), .rs2_val(rs2_val), .rd_idx(rd_idx), .rd_we(rd_we),
    .instr(instr), .instr_type(instr_type), .flush(flush),
    .out_valid(sat_out_valid), .out_ready(out_ready),
    .alu_result_out(sat_alu_result_out), .rs2_val_out(sat_rs2_val_out),
    .rd_idx_out(sat_rd_idx_out), .rd_we_out(sat_rd_we_out), .instr_out(sat_instr_out),
    .instr_type_out(sat_instr_type_out), .stall_cnt(sat_stall_cnt)
  );

  always #5 clk = ~clk;

  function automatic ex_mem_payload_t mkPayload(input logic [31:0] a);
    ex_mem_payload_t p;
    p.alu_result = a;
    p.rs2_val    = a ^ 32'hFFFF_0000;
    p.rd_idx     = a[4:0];
    p.rd_we      = a[0];
    p.instr      = {a[15:0], 16'h0013};
    p.instr_type = a[3:0];
    return p;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs; bubbles carry rd_we=1/rd_idx=7 garbage.
  task automatic applyStimulus(input logic v, input logic [31:0] a, input logic rdy, input logic fl);
    ex_mem_payload_t p;
    p          = mkPayload(a);
    in_valid   = v;
    alu_result = p.alu_result;
    rs2_val    = p.rs2_val;
    rd_idx     = v ? p.rd_idx : 5'd7;
    rd_we      = v ? p.rd_we : 1'b1;
    instr      = p.instr;
    instr_type = p.instr_type;
    out_ready  = rdy;
    flush      = fl;
    #1;
  endtask

  // Score the handshakes of the current cycle, then advance to the next negedge.
  task automatic tickCycle();
    ex_mem_payload_t e;
    if (out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checkOutput("unexpected_beat", {63'd0, out_valid}, 64'd0);
      end else begin
        e = sb.pop_front();
        checkOutput("alu_result_out", alu_result_out, e.alu_result);
        checkOutput("rs2_val_out", rs2_val_out, e.rs2_val);
        checkOutput("rd_idx_out", rd_idx_out, e.rd_idx);
        checkOutput("rd_we_out", rd_we_out, e.rd_we);
        checkOutput("instr_out", instr_out, e.instr);
        checkOutput("instr_type_out", instr_type_out, e.instr_type);
      end
    end
    if (flush) sb.delete();
    else if (in_valid && in_ready) sb.push_back(mkPayload(alu_result));
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    applyStimulus(1'b0, 32'd0, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("reset_out_valid", out_valid, 0);
    checkOutput("reset_rd_we_out", rd_we_out, 0);
    checkOutput("reset_alu_result_out", alu_result_out, 0);
    checkOutput("reset_stall_cnt", stall_cnt, 0);
    checkOutput("reset_in_ready", in_ready, 1);
    rst = 1'b0;

    $display("[TB] streaming");
    for (int i = 1; i <= 8; i++) begin
      applyStimulus(1'b1, 32'(i), 1'b1, 1'b0);
      tickCycle();
      checkOutput("stream_out_valid", out_valid, 1);
    end
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b0, 32'd0, 1'b1, 1'b0);
      tickCycle();
    end
    checkOutput("stream_drained_valid", out_valid, 0);
    checkOutput("stream_sb_empty", 64'(sb.size()), 0);

    $display("[TB] back-pressure");
    applyStimulus(1'b1, 32'h1234, 1'b0, 1'b0);
    tickCycle();
    for (int k = 0; k < 5; k++) begin
      applyStimulus(1'b1, 32'h5678, 1'b0, 1'b0);
      checkOutput("bp_in_ready", in_ready, (SKID && k == 0) ? 1 : 0);
      checkOutput("bp_out_valid", out_valid, 1);
      checkOutput("bp_alu_stable", alu_result_out, 32'h1234);
      checkOutput("bp_instr_stable", instr_out, {16'h1234, 16'h0013});
      tickCycle();
    end
    checkOutput("bp_stall_cnt", stall_cnt, 5);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b0, 32'd0, 1'b1, 1'b0);
      tickCycle();
    end
    checkOutput("bp_drained_valid", out_valid, 0);
    checkOutput("bp_sb_empty", 64'(sb.size()), 0);

    $display("[TB] flush");
    applyStimulus(1'b1, 32'hAAAB, 1'b0, 1'b0);
    tickCycle();
    checkOutput("flush_pre_valid", out_valid, 1);
    checkOutput("flush_pre_rd_we", rd_we_out, 1);
    applyStimulus(1'b1, 32'hBBBB, 1'b0, 1'b1);
    tickCycle();
    checkOutput("flush_out_valid", out_valid, 0);
    checkOutput("flush_rd_we_out", rd_we_out, 0);
    checkOutput("flush_keeps_stall_cnt", stall_cnt, 6);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b0, 32'd0, 1'b1, 1'b0);
      tickCycle();
      checkOutput("flush_no_emerge", out_valid, 0);
    end

    $display("[TB] bubble gating");
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b0, 32'd0, 1'b0, 1'b0);
      tickCycle();
      checkOutput("bubble_out_valid", out_valid, 0);
      checkOutput("bubble_rd_we_out", rd_we_out, 0);
    end
    checkOutput("bubble_stall_cnt", stall_cnt, 6);

    $display("[TB] reset mid-stream");
    applyStimulus(1'b1, 32'hDEADBEEF, 1'b0, 1'b0);
    tickCycle();
    applyStimulus(1'b0, 32'd0, 1'b0, 1'b0);
    tickCycle();
    checkOutput("mid_pre_alu", alu_result_out, 32'hDEADBEEF);
    checkOutput("mid_pre_valid", out_valid, 1);
    #1;
    rst = 1'b1;
    #1;
    checkOutput("mid_out_valid", out_valid, 0);
    checkOutput("mid_alu_result_out", alu_result_out, 0);
    checkOutput("mid_instr_out", instr_out, 0);
    checkOutput("mid_rd_we_out", rd_we_out, 0);
    checkOutput("mid_stall_cnt", stall_cnt, 0);
    checkOutput("mid_sat_stall_cnt", sat_stall_cnt, 0);
    sb.delete();
    @(negedge clk);
    rst = 1'b0;

    $display("[TB] counter saturation");
    applyStimulus(1'b1, 32'h55, 1'b0, 1'b0);
    tickCycle();
    for (int k = 1; k <= 20; k++) begin
      applyStimulus(1'b0, 32'd0, 1'b0, 1'b0);
      tickCycle();
      if (k == 14) checkOutput("sat_cnt_14", sat_stall_cnt, 14);
      if (k == 15) checkOutput("sat_cnt_15", sat_stall_cnt, 15);
    end
    checkOutput("sat_cnt_held", sat_stall_cnt, 15);
    checkOutput("wide_cnt_20", stall_cnt, 20);
    for (int k = 0; k < 2; k++) begin
      applyStimulus(1'b0, 32'd0, 1'b1, 1'b0);
      tickCycle();
    end
    checkOutput("sat_sb_empty", 64'(sb.size()), 0);
    checkOutput("sat_cnt_after_release", sat_stall_cnt, 15);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
